// File: rtl/hf_io_pkg.sv
// Shared types and helpers for the hf_io_hub peripheral conditioning block.
package hf_io_pkg;

  typedef logic [7:0] seg7_t;

  localparam seg7_t SEG_BLANK = 8'hFF;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_t;

  // Active-low segments, bit7 = DP (left off), bits6:0 = g..a.
  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    seg7_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hf_debounce.sv
// Two-flop synchroniser plus per-bit counter debounce with registered rise/fall pulses.
module hf_debounce
  import hf_io_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CYCLES  = 2,
  parameter logic        RST_VAL = 1'b0,
  parameter logic        INVERT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned     CW   = $clog2(CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] d_next;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= {WIDTH{RST_VAL}};
      sync2 <= {WIDTH{RST_VAL}};
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Polarity is flipped only after the synchroniser so the first flop sees the pin directly.
  always_comb begin
    s = sync2 ^ {WIDTH{INVERT}};
  end

  always_comb begin
    d_next = d;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s[i] != d[i]) begin
        if (cnt[i] == LAST) begin
          d_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d    <= '0;
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      d    <= d_next;
      rise <= d_next & ~d;
      fall <= ~d_next & d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: rtl/hf_io_hub.sv
// Peripheral conditioning hub: debounced switches/keys, seven-segment drive with blink,
// and tear-free capture of the pin_ip parameter words.
module hf_io_hub
  import hf_io_pkg::*;
#(
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned NUM_KEY         = 2,
  parameter int unsigned NUM_DIGITS      = 6,
  parameter int unsigned NUM_PARAM       = 3,
  parameter int unsigned PARAM_W         = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic                         max10_clk1_50,
  input  logic                         reset,
  input  logic [NUM_SW-1:0]            sw_raw,
  input  logic [NUM_KEY-1:0]           key_n_raw,
  output logic [NUM_SW-1:0]            sw_db,
  output logic [NUM_KEY-1:0]           key_db,
  output logic [NUM_KEY-1:0]           key_press,
  output logic [NUM_KEY-1:0]           key_release,
  input  logic [4*NUM_DIGITS-1:0]      hex_value,
  input  logic [NUM_DIGITS-1:0]        hex_blank,
  input  logic [NUM_DIGITS-1:0]        hex_blink,
  input  logic [NUM_DIGITS-1:0]        hex_dp,
  output logic [8*NUM_DIGITS-1:0]      hex_seg,
  input  logic [NUM_PARAM*PARAM_W-1:0] param_raw,
  output logic [NUM_PARAM*PARAM_W-1:0] param_q,
  output logic [NUM_PARAM-1:0]         param_upd
);

  localparam int unsigned   BW         = $clog2(BLINK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [NUM_SW-1:0] sw_rise_unused;
  logic [NUM_SW-1:0] sw_fall_unused;

  hf_debounce #(
    .WIDTH   (NUM_SW),
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL (1'b0),
    .INVERT  (1'b0)
  ) u_sw_debounce (
    .clk   (max10_clk1_50),
    .reset (reset),
    .raw   (sw_raw),
    .d     (sw_db),
    .rise  (sw_rise_unused),
    .fall  (sw_fall_unused)
  );

  // Keys idle high on the pins; syncs reset to released, output is 1 = pressed.
  hf_debounce #(
    .WIDTH   (NUM_KEY),
    .CYCLES  (DEBOUNCE_CYCLES),
    .RST_VAL (1'b1),
    .INVERT  (1'b1)
  ) u_key_debounce (
    .clk   (max10_clk1_50),
    .reset (reset),
    .raw   (key_n_raw),
    .d     (key_db),
    .rise  (key_press),
    .fall  (key_release)
  );

  logic [BW-1:0]  blink_cnt;
  blink_phase_t   blink_phase;

  always_ff @(posedge max10_clk1_50) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= BLINK_ON;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
    end else begin
      blink_cnt   <= blink_cnt + BW'(1);
    end
  end

  logic [8*NUM_DIGITS-1:0] seg_next;

  always_comb begin
    seg_next = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      seg_next[8*i +: 8] = hex_to_seg(hex_value[4*i +: 4]);
      if (hex_dp[i]) begin
        seg_next[8*i + 7] = 1'b0;
      end
      if (hex_blank[i] || (hex_blink[i] && blink_phase == BLINK_OFF)) begin
        seg_next[8*i +: 8] = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge max10_clk1_50) begin
    if (reset) begin
      hex_seg <= '1;
    end else begin
      hex_seg <= seg_next;
    end
  end

  logic [NUM_PARAM*PARAM_W-1:0] param_s1;
  logic [NUM_PARAM*PARAM_W-1:0] param_s2;

  // A word is accepted only once two consecutive samples agree, so a word caught mid-write never lands.
  always_ff @(posedge max10_clk1_50) begin
    if (reset) begin
      param_s1  <= '0;
      param_s2  <= '0;
      param_q   <= '0;
      param_upd <= '0;
    end else begin
      param_s1 <= param_raw;
      param_s2 <= param_s1;
      for (int unsigned i = 0; i < NUM_PARAM; i++) begin
        if ((param_s1[i*PARAM_W +: PARAM_W] == param_s2[i*PARAM_W +: PARAM_W]) &&
            (param_s2[i*PARAM_W +: PARAM_W] != param_q[i*PARAM_W +: PARAM_W])) begin
          param_q[i*PARAM_W +: PARAM_W] <= param_s2[i*PARAM_W +: PARAM_W];
          param_upd[i]                  <= 1'b1;
        end else begin
          param_upd[i]                  <= 1'b0;
        end
      end
    end
  end

endmodule
